// File: rtl/load_writeback_unit_pkg.sv
// Shared widths and types for the writeback stage: register-file geometry,
// load funct3 encodings and the pending-load queue entry.
// No ports; imported by the interface, the top and the load aligner.
package riscv_definitions;

  localparam int DATA_WIDTH = 32;
  localparam int REG_ADDR   = 5;
  localparam int REG_COUNT  = 32;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_e;

  // funct3 is kept as raw bits so undefined encodings survive to the aligner
  typedef struct packed {
    logic [REG_ADDR-1:0] rd;
    logic [2:0]          funct3;
    logic [1:0]          addr_lo;
  } pending_load_t;

endpackage

// File: rtl/load_writeback_unit_if.sv
// Bundle of the writeback unit's handshake and data signals.
// Ports: ALU result (valid/rd/data), load issue (valid/rd/funct3/addr_lo/ready),
// memory response (valid/data/ready), register-file write and busy mask.
interface load_writeback_unit_if;
  import riscv_definitions::*;

  logic                  i_alu_valid;
  logic [REG_ADDR-1:0]   i_alu_rd;
  logic [DATA_WIDTH-1:0] i_alu_data;
  logic                  i_load_issue_valid;
  logic [REG_ADDR-1:0]   i_load_issue_rd;
  logic [2:0]            i_load_issue_funct3;
  logic [1:0]            i_load_issue_addr_lo;
  logic                  o_load_issue_ready;
  logic                  i_mem_rsp_valid;
  logic [DATA_WIDTH-1:0] i_mem_rsp_data;
  logic                  o_mem_rsp_ready;
  logic                  o_wr_reg_en;
  logic [REG_ADDR-1:0]   o_write_register_addr;
  logic [DATA_WIDTH-1:0] o_write_data;
  logic [REG_COUNT-1:0]  o_busy_mask;

  // master: execute/memory side driving the unit
  modport master (
    output i_alu_valid, i_alu_rd, i_alu_data,
    output i_load_issue_valid, i_load_issue_rd, i_load_issue_funct3, i_load_issue_addr_lo,
    input  o_load_issue_ready,
    output i_mem_rsp_valid, i_mem_rsp_data,
    input  o_mem_rsp_ready,
    input  o_wr_reg_en, o_write_register_addr, o_write_data, o_busy_mask
  );

  // slave: the writeback unit itself
  modport slave (
    input  i_alu_valid, i_alu_rd, i_alu_data,
    input  i_load_issue_valid, i_load_issue_rd, i_load_issue_funct3, i_load_issue_addr_lo,
    output o_load_issue_ready,
    input  i_mem_rsp_valid, i_mem_rsp_data,
    output o_mem_rsp_ready,
    output o_wr_reg_en, o_write_register_addr, o_write_data, o_busy_mask
  );

endinterface

// File: rtl/load_writeback_unit_align.sv
// Load aligner: picks the byte/halfword lane of a memory word and extends it.
// Latency: purely combinational. Backpressure: none.
// Ports: i_word (raw word), i_funct3 (load type), i_addr_lo (byte offset), o_data.
module load_align
  import riscv_definitions::*;
(
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic [2:0]            i_funct3,
  input  logic [1:0]            i_addr_lo,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'(i_word >> {i_addr_lo, 3'b000});
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    case (i_funct3)
      F3_LB:   o_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      F3_LBU:  o_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      F3_LHU:  o_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: o_data = i_word;  // LW and any undefined encoding
    endcase
  end

endmodule

// File: rtl/load_writeback_unit.sv
// Writeback stage: merges ALU results and in-order load responses onto the single RF write port.
// Latency: ALU 1 cycle; load response -> hold 1 cycle -> RF write 1 cycle later when ALU idle.
// Backpressure: issue stalls when queue full or rd busy; responses stall while the hold register is full.
// Ports: i_clk, i_rst (sync, active-high), wb (load_writeback_unit_if.slave).
// Optional: define WB_ASSERTIONS_EN to compile protocol assertions.
module load_writeback_unit #(
  parameter int LOAD_DEPTH = 4
) (
  input logic                  i_clk,
  input logic                  i_rst,
  load_writeback_unit_if.slave wb
);
  import riscv_definitions::*;

  localparam int             PTR_W   = $clog2(LOAD_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  pending_load_t         r_queue [LOAD_DEPTH];
  logic [PTR_W:0]        r_wr_ptr, r_rd_ptr;
  logic [REG_COUNT-1:0]  r_busy, w_busy_next;
  logic                  r_hold_vld;
  logic [REG_ADDR-1:0]   r_hold_rd;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_wr_en, r_wr_is_load;
  logic [REG_ADDR-1:0]   r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;

  logic                  w_empty, w_full, w_issue_rdy, w_rsp_rdy, w_push, w_pop;
  pending_load_t         w_head, w_new;
  logic [DATA_WIDTH-1:0] w_aligned;
  logic                  w_sel_vld, w_sel_load;
  logic [REG_ADDR-1:0]   w_sel_rd;
  logic [DATA_WIDTH-1:0] w_sel_data;

  // Wrap bit differs but index matches -> full
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_head  = r_queue[r_rd_ptr[PTR_W-1:0]];
  assign w_new   = '{rd: wb.i_load_issue_rd, funct3: wb.i_load_issue_funct3,
                     addr_lo: wb.i_load_issue_addr_lo};

  // Registered busy mask blocks a second load to the same rd (WAW)
  assign w_issue_rdy = !w_full && ((wb.i_load_issue_rd == '0) || !r_busy[wb.i_load_issue_rd]);
  assign w_rsp_rdy   = !w_empty && !r_hold_vld;
  assign w_push      = wb.i_load_issue_valid && w_issue_rdy;
  assign w_pop       = wb.i_mem_rsp_valid && w_rsp_rdy;

  load_align u_align (
    .i_word    (wb.i_mem_rsp_data),
    .i_funct3  (w_head.funct3),
    .i_addr_lo (w_head.addr_lo),
    .o_data    (w_aligned)
  );

  // ALU has priority; a held load result waits until the ALU is idle
  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel_load = 1'b0;
    w_sel_rd   = '0;
    w_sel_data = '0;
    if (wb.i_alu_valid) begin
      w_sel_vld  = 1'b1;
      w_sel_rd   = wb.i_alu_rd;
      w_sel_data = wb.i_alu_data;
    end else if (r_hold_vld) begin
      w_sel_vld  = 1'b1;
      w_sel_load = 1'b1;
      w_sel_rd   = r_hold_rd;
      w_sel_data = r_hold_data;
    end
  end

  // A load's busy bit drops on the edge closing the cycle its write is presented
  always_comb begin
    w_busy_next = r_busy;
    if (r_wr_en && r_wr_is_load) w_busy_next[r_wr_addr] = 1'b0;
    if (w_push) w_busy_next[wb.i_load_issue_rd] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_queue[r_wr_ptr[PTR_W-1:0]] <= w_new;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_busy       <= '0;
      r_hold_vld   <= 1'b0;
      r_hold_rd    <= '0;
      r_hold_data  <= '0;
      r_wr_en      <= 1'b0;
      r_wr_is_load <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_busy <= w_busy_next;
      // A pop can only happen with hold empty, so load and drain never collide
      if (w_pop) begin
        r_hold_vld  <= 1'b1;
        r_hold_rd   <= w_head.rd;
        r_hold_data <= w_aligned;
      end else if (!wb.i_alu_valid && r_hold_vld) begin
        r_hold_vld <= 1'b0;
      end
      r_wr_en      <= w_sel_vld && (w_sel_rd != '0);
      r_wr_is_load <= w_sel_load;
      r_wr_addr    <= w_sel_rd;
      r_wr_data    <= w_sel_data;
    end
  end

  assign wb.o_load_issue_ready    = w_issue_rdy;
  assign wb.o_mem_rsp_ready       = w_rsp_rdy;
  assign wb.o_wr_reg_en           = r_wr_en;
  assign wb.o_write_register_addr = r_wr_addr;
  assign wb.o_write_data          = r_wr_data;
  assign wb.o_busy_mask           = r_busy;

`ifdef WB_ASSERTIONS_EN
  a_alu_busy_rd: assert property (@(posedge i_clk) disable iff (i_rst)
    (wb.i_alu_valid && wb.i_alu_rd != '0) |-> !r_busy[wb.i_alu_rd]);
  a_rsp_empty: assert property (@(posedge i_clk) disable iff (i_rst)
    wb.i_mem_rsp_valid |-> !w_empty);
  a_rsp_known: assert property (@(posedge i_clk) disable iff (i_rst)
    wb.i_mem_rsp_valid |-> !$isunknown(wb.i_mem_rsp_data));
  a_busy_x0: assert property (@(posedge i_clk) disable iff (i_rst)
    !r_busy[0]);
`else
  // Checks compiled out; datapath is unchanged.
`endif

endmodule

// File: tb/tb_load_writeback_unit.sv
// Directed bench for load_writeback_unit: extension table, queue full, arbitration,
// WAW/x0 and mid-operation reset, against hand-computed expectations.
module tb_load_writeback_unit;
  import riscv_definitions::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  load_writeback_unit_if u_if();

  load_writeback_unit #(.LOAD_DEPTH(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .wb    (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string tag, input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
    u_if.i_load_issue_valid   = 1'b1;
    u_if.i_load_issue_rd      = rd;
    u_if.i_load_issue_funct3  = f3;
    u_if.i_load_issue_addr_lo = lo;
    #1;
    check({tag, "_issue_rdy"}, 32'(u_if.o_load_issue_ready), 1);
    tick();
    u_if.i_load_issue_valid = 1'b0;
  endtask

  // Response accepted in this cycle (M); write expected in M+2. Returns in M+2.
  task automatic respond(input string tag, input logic [31:0] word, input logic [4:0] rd,
                         input logic [31:0] exp);
    u_if.i_mem_rsp_valid = 1'b1;
    u_if.i_mem_rsp_data  = word;
    #1;
    check({tag, "_rsp_rdy"}, 32'(u_if.o_mem_rsp_ready), 1);
    tick();
    u_if.i_mem_rsp_valid = 1'b0;
    check({tag, "_en_m1"}, 32'(u_if.o_wr_reg_en), 0);
    tick();
    check({tag, "_en_m2"}, 32'(u_if.o_wr_reg_en), (rd != 5'd0) ? 1 : 0);
    if (rd != 5'd0) begin
      check({tag, "_addr"}, 32'(u_if.o_write_register_addr), 32'(rd));
      check({tag, "_data"}, u_if.o_write_data, exp);
    end
  endtask

  // Extension table: all against word 0x80FF_1234
  localparam int NT = 10;
  logic [4:0]  t_rd  [NT] = '{5'd5, 5'd6, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17};
  logic [2:0]  t_f3  [NT] = '{3'b000, 3'b101, 3'b001, 3'b100, 3'b001, 3'b000, 3'b010, 3'b011, 3'b100, 3'b000};
  logic [1:0]  t_lo  [NT] = '{2'd3, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2};
  logic [31:0] t_exp [NT] = '{32'hFFFF_FF80, 32'h0000_80FF, 32'hFFFF_80FF, 32'h0000_0080,
                              32'h0000_1234, 32'h0000_0012, 32'h80FF_1234, 32'h80FF_1234,
                              32'h0000_00FF, 32'hFFFF_FFFF};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    u_if.i_alu_valid = 1'b0;
    u_if.i_alu_rd = '0;
    u_if.i_alu_data = '0;
    u_if.i_load_issue_valid = 1'b0;
    u_if.i_load_issue_rd = '0;
    u_if.i_load_issue_funct3 = '0;
    u_if.i_load_issue_addr_lo = '0;
    u_if.i_mem_rsp_valid = 1'b0;
    u_if.i_mem_rsp_data = '0;
    tick();
    tick();
    check("rst_en", 32'(u_if.o_wr_reg_en), 0);
    check("rst_addr", 32'(u_if.o_write_register_addr), 0);
    check("rst_data", u_if.o_write_data, 0);
    check("rst_busy", u_if.o_busy_mask, 0);
    check("rst_rsp_rdy", 32'(u_if.o_mem_rsp_ready), 0);
    rst = 1'b0;
    tick();

    // Load extension table
    for (int i = 0; i < NT; i++) begin
      issue($sformatf("ext%0d", i), t_rd[i], t_f3[i], t_lo[i]);
      respond($sformatf("ext%0d", i), 32'h80FF_1234, t_rd[i], t_exp[i]);
      check($sformatf("ext%0d_busy_set", i), u_if.o_busy_mask, 32'd1 << t_rd[i]);
      tick();
      check($sformatf("ext%0d_busy_clr", i), u_if.o_busy_mask, 0);
    end

    // Queue full: x1..x4 outstanding, then a pop does not let a push through the same cycle
    for (int i = 1; i <= 4; i++) issue($sformatf("full%0d", i), 5'(i), 3'b010, 2'd0);
    u_if.i_load_issue_valid = 1'b1;
    u_if.i_load_issue_rd    = 5'd10;
    u_if.i_mem_rsp_valid    = 1'b1;
    u_if.i_mem_rsp_data     = 32'hAAAA_0001;
    #1;
    check("full_issue_rdy", 32'(u_if.o_load_issue_ready), 0);
    check("full_busy", u_if.o_busy_mask, 32'h0000_001E);
    check("full_rsp_rdy", 32'(u_if.o_mem_rsp_ready), 1);
    tick();
    u_if.i_mem_rsp_valid = 1'b0;
    #1;
    check("full_issue_rdy_after_pop", 32'(u_if.o_load_issue_ready), 1);
    u_if.i_load_issue_valid = 1'b0;
    tick();
    check("full_x1_en", 32'(u_if.o_wr_reg_en), 1);
    check("full_x1_addr", 32'(u_if.o_write_register_addr), 1);
    check("full_x1_data", u_if.o_write_data, 32'hAAAA_0001);
    tick();
    check("full_busy_x1_clr", u_if.o_busy_mask, 32'h0000_001C);
    for (int i = 2; i <= 4; i++) respond($sformatf("drain%0d", i), 32'(i), 5'(i), 32'(i));
    tick();
    check("drain_busy", u_if.o_busy_mask, 0);

    // Arbitration: x8 result in hold while ALU writes x7 three times
    issue("arb8", 5'd8, 3'b010, 2'd0);
    issue("arb9", 5'd9, 3'b010, 2'd0);
    u_if.i_mem_rsp_valid = 1'b1;
    u_if.i_mem_rsp_data  = 32'h1234_5678;
    tick();
    u_if.i_mem_rsp_data  = 32'hCAFE_BABE;
    u_if.i_alu_valid     = 1'b1;
    u_if.i_alu_rd        = 5'd7;
    u_if.i_alu_data      = 32'h11;
    #1;
    check("arb_rsp_rdy_0", 32'(u_if.o_mem_rsp_ready), 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i == 3) u_if.i_alu_valid = 1'b0;
      #1;
      check($sformatf("arb_alu%0d_en", i), 32'(u_if.o_wr_reg_en), 1);
      check($sformatf("arb_alu%0d_addr", i), 32'(u_if.o_write_register_addr), 7);
      check($sformatf("arb_alu%0d_data", i), u_if.o_write_data, 32'h11);
      check($sformatf("arb_rsp_rdy_%0d", i), 32'(u_if.o_mem_rsp_ready), 0);
    end
    tick();
    check("arb_x8_en", 32'(u_if.o_wr_reg_en), 1);
    check("arb_x8_addr", 32'(u_if.o_write_register_addr), 8);
    check("arb_x8_data", u_if.o_write_data, 32'h1234_5678);
    check("arb_rsp_rdy_free", 32'(u_if.o_mem_rsp_ready), 1);
    tick();
    u_if.i_mem_rsp_valid = 1'b0;
    check("arb_busy_x9", u_if.o_busy_mask, 32'h0000_0200);
    tick();
    check("arb_x9_addr", 32'(u_if.o_write_register_addr), 9);
    check("arb_x9_data", u_if.o_write_data, 32'hCAFE_BABE);
    tick();
    check("arb_busy_clr", u_if.o_busy_mask, 0);

    // WAW on x9: second issue held until the first write has retired
    issue("waw_a", 5'd9, 3'b010, 2'd0);
    u_if.i_load_issue_valid = 1'b1;
    u_if.i_load_issue_rd    = 5'd9;
    u_if.i_mem_rsp_valid    = 1'b1;
    u_if.i_mem_rsp_data     = 32'h55;
    #1;
    check("waw_blk_m0", 32'(u_if.o_load_issue_ready), 0);
    tick();
    u_if.i_mem_rsp_valid = 1'b0;
    #1;
    check("waw_blk_m1", 32'(u_if.o_load_issue_ready), 0);
    tick();
    check("waw_a_data", u_if.o_write_data, 32'h55);
    check("waw_blk_m2", 32'(u_if.o_load_issue_ready), 0);
    tick();
    check("waw_rdy_m3", 32'(u_if.o_load_issue_ready), 1);
    tick();
    u_if.i_load_issue_valid = 1'b0;
    check("waw_b_busy", u_if.o_busy_mask, 32'h0000_0200);
    respond("waw_b", 32'h66, 5'd9, 32'h66);
    tick();
    check("waw_busy_clr", u_if.o_busy_mask, 0);

    // Load to x0: consumed, never written, never busy
    issue("x0", 5'd0, 3'b010, 2'd0);
    check("x0_busy", u_if.o_busy_mask, 0);
    respond("x0", 32'h77, 5'd0, 32'h0);
    tick();
    check("x0_en_m3", 32'(u_if.o_wr_reg_en), 0);
    check("x0_empty", 32'(u_if.o_mem_rsp_ready), 0);

    // Reset with three loads outstanding and a result in hold
    for (int i = 1; i <= 4; i++) issue($sformatf("mrst%0d", i), 5'(i), 3'b010, 2'd0);
    u_if.i_mem_rsp_valid = 1'b1;
    u_if.i_mem_rsp_data  = 32'h99;
    tick();
    u_if.i_mem_rsp_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("mrst_en", 32'(u_if.o_wr_reg_en), 0);
    check("mrst_addr", 32'(u_if.o_write_register_addr), 0);
    check("mrst_data", u_if.o_write_data, 0);
    check("mrst_busy", u_if.o_busy_mask, 0);
    check("mrst_rsp_rdy", 32'(u_if.o_mem_rsp_ready), 0);
    rst = 1'b0;
    tick();
    check("mrst_hold_gone1", 32'(u_if.o_wr_reg_en), 0);
    tick();
    check("mrst_hold_gone2", 32'(u_if.o_wr_reg_en), 0);
    check("mrst_still_empty", 32'(u_if.o_mem_rsp_ready), 0);
    u_if.i_load_issue_rd = 5'd2;
    #1;
    check("mrst_issue_rdy", 32'(u_if.o_load_issue_ready), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
